// File: rtl/core_io_axi.sv
// Byte-wide IN/OUT port for the core, bridged to a UART-Lite over an AXI-Lite master.
// Each request polls the status register until the FIFO is usable, then moves one byte.
module core_io_axi #(
  parameter logic [3:0] STAT_ADDR = 4'h8,
  parameter logic [3:0] RX_ADDR   = 4'h0,
  parameter logic [3:0] TX_ADDR   = 4'h4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_IN,
  input  logic        REQ_OUT,
  input  logic [7:0]  OUT_DATA,
  output logic [7:0]  IN_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [3:0]  M_AWADDR,
  output logic        M_AWVALID,
  input  logic        M_AWREADY,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_WSTRB,
  output logic        M_WVALID,
  input  logic        M_WREADY,
  input  logic [1:0]  M_BRESP,
  input  logic        M_BVALID,
  output logic        M_BREADY,
  output logic [3:0]  M_ARADDR,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP,
  input  logic        M_RVALID,
  output logic        M_RREADY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ST_AR  = 3'd1,
    ST_R   = 3'd2,
    RX_AR  = 3'd3,
    RX_R   = 3'd4,
    TX_AWW = 3'd5,
    TX_B   = 3'd6,
    FIN    = 3'd7
  } state_t;

  state_t      state_r, state_s;
  logic        mode_tx_r, mode_tx_s;
  logic [7:0]  byte_r, byte_s;
  logic [7:0]  in_data_r, in_data_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic [3:0]  awaddr_r, awaddr_s;
  logic        awvalid_r, awvalid_s;
  logic [31:0] wdata_r, wdata_s;
  logic [3:0]  wstrb_r, wstrb_s;
  logic        wvalid_r, wvalid_s;
  logic        bready_r, bready_s;
  logic [3:0]  araddr_r, araddr_s;
  logic        arvalid_r, arvalid_s;
  logic        rready_r, rready_s;

  logic        r_hs_s;
  logic        b_hs_s;
  logic        aw_left_s;
  logic        w_left_s;
  logic        unused_rdata_s;

  // An errored status response is treated as all-zero bits, which never reports "usable".
  function automatic logic stat_usable(input logic tx_mode, input logic rx_avail,
                                       input logic tx_full, input logic [1:0] resp);
    logic ok;
    if (resp != 2'b00) begin
      ok = 1'b0;
    end else if (tx_mode) begin
      ok = ~tx_full;
    end else begin
      ok = rx_avail;
    end
    return ok;
  endfunction

  assign r_hs_s         = M_RVALID & rready_r;
  assign b_hs_s         = M_BVALID & bready_r;
  assign aw_left_s      = awvalid_r & ~M_AWREADY;
  assign w_left_s       = wvalid_r & ~M_WREADY;
  assign unused_rdata_s = ^M_RDATA[31:8];

  // Next-state and next-output decode; every output is taken from a flop.
  always_comb begin
    state_s   = state_r;
    mode_tx_s = mode_tx_r;
    byte_s    = byte_r;
    in_data_s = in_data_r;
    awaddr_s  = awaddr_r;
    awvalid_s = awvalid_r;
    wdata_s   = wdata_r;
    wstrb_s   = wstrb_r;
    wvalid_s  = wvalid_r;
    araddr_s  = araddr_r;
    arvalid_s = arvalid_r;
    err_s     = err_r
              | (r_hs_s & (M_RRESP != 2'b00))
              | (b_hs_s & (M_BRESP != 2'b00));

    case (state_r)
      IDLE: begin
        if (REQ_OUT) begin
          state_s   = ST_AR;
          mode_tx_s = 1'b1;
          byte_s    = OUT_DATA;
          arvalid_s = 1'b1;
          araddr_s  = STAT_ADDR;
        end else if (REQ_IN) begin
          state_s   = ST_AR;
          mode_tx_s = 1'b0;
          arvalid_s = 1'b1;
          araddr_s  = STAT_ADDR;
        end else begin
          state_s   = IDLE;
        end
      end
      ST_AR: begin
        if (M_ARREADY) begin
          state_s   = ST_R;
          arvalid_s = 1'b0;
        end else begin
          state_s   = ST_AR;
        end
      end
      ST_R: begin
        if (!r_hs_s) begin
          state_s = ST_R;
        end else if (!stat_usable(mode_tx_r, M_RDATA[0], M_RDATA[3], M_RRESP)) begin
          state_s   = ST_AR;
          arvalid_s = 1'b1;
          araddr_s  = STAT_ADDR;
        end else if (mode_tx_r) begin
          state_s   = TX_AWW;
          awvalid_s = 1'b1;
          awaddr_s  = TX_ADDR;
          wvalid_s  = 1'b1;
          wdata_s   = {24'h000000, byte_r};
          wstrb_s   = 4'b1111;
        end else begin
          state_s   = RX_AR;
          arvalid_s = 1'b1;
          araddr_s  = RX_ADDR;
        end
      end
      RX_AR: begin
        if (M_ARREADY) begin
          state_s   = RX_R;
          arvalid_s = 1'b0;
        end else begin
          state_s   = RX_AR;
        end
      end
      RX_R: begin
        if (r_hs_s) begin
          state_s   = FIN;
          in_data_s = M_RDATA[7:0];
        end else begin
          state_s   = RX_R;
        end
      end
      TX_AWW: begin
        // Address and data handshakes may complete in either order.
        awvalid_s = aw_left_s;
        wvalid_s  = w_left_s;
        if (!aw_left_s && !w_left_s) begin
          state_s = TX_B;
        end else begin
          state_s = TX_AWW;
        end
      end
      TX_B: begin
        if (b_hs_s) begin
          state_s = FIN;
        end else begin
          state_s = TX_B;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        arvalid_s = 1'b0;
      end
    endcase

    rready_s = (state_s == ST_R) || (state_s == RX_R);
    bready_s = (state_s == TX_B);
    done_s   = (state_s == FIN);
    busy_s   = (state_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      mode_tx_r <= 1'b0;
      byte_r    <= 8'h00;
      in_data_r <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      awaddr_r  <= 4'h0;
      awvalid_r <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      araddr_r  <= 4'h0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      mode_tx_r <= mode_tx_s;
      byte_r    <= byte_s;
      in_data_r <= in_data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      awaddr_r  <= awaddr_s;
      awvalid_r <= awvalid_s;
      wdata_r   <= wdata_s;
      wstrb_r   <= wstrb_s;
      wvalid_r  <= wvalid_s;
      bready_r  <= bready_s;
      araddr_r  <= araddr_s;
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
    end
  end

  assign IN_DATA   = in_data_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign ERR       = err_r;
  assign M_AWADDR  = awaddr_r;
  assign M_AWVALID = awvalid_r;
  assign M_WDATA   = wdata_r;
  assign M_WSTRB   = wstrb_r;
  assign M_WVALID  = wvalid_r;
  assign M_BREADY  = bready_r;
  assign M_ARADDR  = araddr_r;
  assign M_ARVALID = arvalid_r;
  assign M_RREADY  = rready_r;

endmodule

// File: doc/core_io_axi.md
CORE_IO_AXI -- requirements
Module: core_io_axi

Interface
REQ-001 Parameter STAT_ADDR, default 4'h8: UART-Lite status register address.
REQ-002 Parameter RX_ADDR, default 4'h0: UART-Lite RX FIFO address.
REQ-003 Parameter TX_ADDR, default 4'h4: UART-Lite TX FIFO address.
REQ-004 CLK  in  1  clock; all state changes on rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 REQ_IN  in  1  single-cycle request from core: read one byte (IN instruction).
REQ-007 REQ_OUT  in  1  single-cycle request from core: write one byte (OUT instruction).
REQ-008 OUT_DATA  in  8  byte to transmit, sampled on REQ_OUT acceptance.
REQ-009 IN_DATA  out  8  received byte, valid from DONE onward until next accepted request.
REQ-010 BUSY  out  1  high from cycle after acceptance through DONE cycle; core stalls on it.
REQ-011 DONE  out  1  one-cycle pulse at transaction completion.
REQ-012 ERR  out  1  sticky flag: any nonzero RRESP/BRESP seen.
REQ-013 M_AWADDR out 4, M_AWVALID out 1, M_AWREADY in 1: AXI-Lite write address channel.
REQ-014 M_WDATA out 32, M_WSTRB out 4, M_WVALID out 1, M_WREADY in 1: write data channel.
REQ-015 M_BRESP in 2, M_BVALID in 1, M_BREADY out 1: write response channel.
REQ-016 M_ARADDR out 4, M_ARVALID out 1, M_ARREADY in 1: read address channel.
REQ-017 M_RDATA in 32, M_RRESP in 2, M_RVALID in 1, M_RREADY out 1: read data channel.

Function
REQ-018 FSM states: IDLE, ST_AR, ST_R, RX_AR, RX_R, TX_AWW, TX_B, FIN.
REQ-019 IDLE: REQ_OUT -> ST_AR (mode TX, latch OUT_DATA); else REQ_IN -> ST_AR (mode RX); both high -> OUT wins, IN dropped.
REQ-020 Requests arriving in any state other than IDLE are ignored (not queued).
REQ-021 ST_AR: ARVALID=1, ARADDR=STAT_ADDR; on ARREADY -> ST_R, ARVALID drops next cycle.
REQ-022 ST_R: RREADY=1; on RVALID: mode RX and RDATA[0]=1 -> RX_AR; mode TX and RDATA[3]=0 -> TX_AWW; otherwise -> ST_AR (re-poll, no idle gap).
REQ-023 RX_AR: ARVALID=1, ARADDR=RX_ADDR; on ARREADY -> RX_R.
REQ-024 RX_R: RREADY=1; on RVALID capture RDATA[7:0] into IN_DATA -> FIN.
REQ-025 TX_AWW: AWVALID=1, AWADDR=TX_ADDR, WVALID=1, WDATA={24'b0,byte}, WSTRB=4'b1111; each VALID drops independently after its READY; when both handshakes done (same or different cycles) -> TX_B.
REQ-026 TX_B: BREADY=1; on BVALID -> FIN.
REQ-027 FIN: DONE=1 for exactly one cycle, BUSY=1 in this cycle, -> IDLE.
REQ-028 VALID signals, once asserted, hold with stable ADDR/DATA until READY (AXI rule).
REQ-029 RREADY/BREADY asserted only in ST_R, RX_R, TX_B; deasserted elsewhere.
REQ-030 Any RVALID with RRESP!=0 or BVALID with BRESP!=0 sets ERR; FSM proceeds as if OKAY (error status read treated as bits=0 -> re-poll).
REQ-031 Minimum latency REQ to DONE with zero-wait slave: IN 6 cycles, OUT 6 cycles; each extra poll adds 2.
REQ-032 No timeout; polling continues indefinitely.

Reset
REQ-033 On RST_N=0 at a clock edge: state IDLE, all VALID/READY outputs 0, BUSY=0, DONE=0, ERR=0, IN_DATA=0, ADDR/DATA outputs 0, WSTRB=0.
REQ-034 Reset mid-transaction abandons it immediately; no completion pulse; slave-side protocol recovery is out of scope.

Verification
REQ-035 REQ_IN, status reads 0x00 twice then 0x01, RX data 0x0000_0041 -> three status reads, one RX read, IN_DATA=0x41, one DONE pulse.
REQ-036 REQ_OUT OUT_DATA=0x5A, status 0x08 once then 0x00 -> two status reads, write AWADDR=0x4 WDATA=0x0000_005A WSTRB=0xF, DONE after BVALID.
REQ-037 TX with AWREADY 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID holds until WREADY, single write, one DONE.
REQ-038 REQ_IN and REQ_OUT same cycle -> only TX transaction performed; second REQ_OUT while BUSY ignored.
REQ-039 BRESP=2'b10 on TX -> ERR=1, DONE still pulses, ERR stays 1 through next clean transaction until reset.
REQ-040 RST_N low while in ST_R with RVALID pending -> next edge all outputs at reset values, BUSY=0, no DONE.
